adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter sharing one `Adder` instance among `NumReq` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes the sum through the shared `Adder`, and holds the tagged result in a single-entry output register until the consumer accepts it. It sits between several client blocks and the shared adder datapath, and is the only driver of that adder's inputs.

## Interface
- `Width`, 8: operand and sum width in bits; passed to the shared `Adder`.
- `NumReq`, 4: number of requesters, 2..16.
- `IdWidth`, `$clog2(NumReq)`: width of the requester tag (localparam).

- `iClk`  in  1  clock; all logic rises on posedge.
- `iRst`  in  1  reset, synchronous, active-high.
- `iReqValid`  in  NumReq  per-requester request valid.
- `oReqReady`  out  NumReq  per-requester accept; at most one bit high per cycle.
- `iReqData0`  in  NumReq*Width  packed operand A; requester i at bits [i*Width +: Width].
- `iReqData1`  in  NumReq*Width  packed operand B, same packing.
- `oRspValid`  out  1  result register holds a valid sum.
- `iRspReady`  in  1  consumer accepts the result.
- `oRspId`  out  IdWidth  index of the requester that produced the result.
- `oRspSum`  out  Width  sum `(A + B) mod 2^Width`.

## Operation
- Output slot FSM has two states:
  - EMPTY: `oRspValid` = 0.
  - FULL: `oRspValid` = 1.
- Transitions:
  - EMPTY -> FULL on a request handshake.
  - FULL -> EMPTY on a response handshake (`oRspValid && iRspReady`) with no new request handshake.
  - FULL -> FULL on a response handshake and a request handshake in the same cycle (back-to-back).
  - FULL holds when `iRspReady` = 0.
- Accept condition: `accept = !oRspValid || iRspReady`.
- Grant is round-robin over `iReqValid`. Search order starts at `(lastGrant + 1) mod NumReq`. `oReqReady[g] = accept && iReqValid[g]` for the single granted index `g`; all other bits are 0.
- `lastGrant` updates to `g` only on a request handshake. If the winner is not accepted, the grant does not rotate.
- On a request handshake, the register loads the granted operand pair through the shared `Adder`:
  - `oRspSum` = Adder output.
  - `oRspId` = `g`.
- Sum wraps modulo `2^Width`; carry-out is discarded unless the feature in Configuration is enabled.
- Requesters hold `iReqValid` and their data stable until `oReqReady` is high. Dropping `iReqValid` without a handshake is allowed; the arbiter simply skips that requester.
- `oRspSum`/`oRspId` stay stable while `oRspValid && !iRspReady`.
- `oReqReady` depends combinationally on `iReqValid` and `iRspReady`. There is no path from `oReqReady` back to `iReqValid`.

## Timing
- Reset values:
  - `oRspValid` = 0, `oRspId` = 0, `oRspSum` = 0, `oReqReady` = 0 during reset.
  - `lastGrant` = `NumReq-1`, so requester 0 has first priority.
  - FSM = EMPTY.
- Latency: a request handshake in cycle N gives `oRspValid` = 1 with its sum in cycle N+1.
- Throughput: one result per cycle while `iRspReady` stays high.
- Stall: `iRspReady` = 0 in a FULL cycle forces all `oReqReady` low that cycle.
- Reset mid-operation: a held result is discarded. The first cycle after reset deasserts is EMPTY with requester 0 prioritized. There is no partial state.
- All valid, consumer always ready: grants cycle 0,1,2,...,NumReq-1,0.
- A single requester held valid continuously is granted every cycle.

## Configuration
- `ADDER_ARB_CARRY_EN` defined:
  - Adds port `oRspCarry  out  1`, reset 0.
  - The shared `Adder` is instantiated at `Width+1` with zero-extended operands. `oRspSum` = low `Width` bits; `oRspCarry` = MSB.
  - `oRspCarry` is registered and held exactly like `oRspSum`.
- `ADDER_ARB_CARRY_EN` undefined: the port is absent, the `Adder` is instantiated at `Width`, and the carry is dropped.

## Test plan
- Reset:
  - Stimulus: `iRst` high 2 cycles with all `iReqValid` = 1.
  - Response: `oReqReady` = 0, `oRspValid` = 0, `oRspSum` = 0 during reset. The first post-reset grant is requester 0.
- Single request, `Width` = 8:
  - Stimulus: requester 2 sends `8'h01 + 8'h02`, `iRspReady` = 1.
  - Response: `oReqReady[2]` high in cycle N. Next cycle `oRspValid` = 1, `oRspId` = 2, `oRspSum` = `8'h03`.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, requester i sending `i + 8'h10`, `iRspReady` = 1.
  - Response: `oRspId` sequence 0,1,2,3,0,... at one result per cycle. Sums `8'h10`, `8'h11`, `8'h12`, `8'h13`.
- Backpressure:
  - Stimulus: result FULL and `iRspReady` = 0 for 3 cycles, all requesters valid.
  - Response: `oReqReady` = 0 and `oRspSum`/`oRspId` stable for all 3 cycles. On the cycle `iRspReady` rises, the next requester in rotation is granted in that same cycle.
- Wrap-around:
  - Stimulus: `8'hFF + 8'h02`.
  - Response: `oRspSum` = `8'h01`. With `ADDER_ARB_CARRY_EN`, `oRspCarry` = 1; `8'h7F + 8'h01` gives `oRspCarry` = 0.
- Reset mid-operation:
  - Stimulus: assert `iRst` while FULL and stalled.
  - Response: `oRspValid` = 0 the next cycle. The pending result is never delivered, and the grant order restarts at requester 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding a shared Adder, with a single-entry tagged result slot.
// Optional ADDER_ARB_CARRY_EN widens the Adder by one bit and exposes the carry as oRspCarry.
module adder_arbiter #(
   parameter  int Width   = 8,
   parameter  int NumReq  = 4,
   localparam int IdWidth = $clog2(NumReq)
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic [NumReq-1:0]         iReqValid,
   output logic [NumReq-1:0]         oReqReady,
   input  logic [NumReq*Width-1:0]   iReqData0,
   input  logic [NumReq*Width-1:0]   iReqData1,
   output logic                      oRspValid,
   input  logic                      iRspReady,
   output logic [IdWidth-1:0]        oRspId,
   output logic [Width-1:0]          oRspSum
`ifdef ADDER_ARB_CARRY_EN
   ,output logic                     oRspCarry
`endif
);

   // Handshakes: a transfer happens on a cycle where valid and ready are both high;
   // requesters hold data until ready, and ready never depends on a ready of the same side.
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

`ifdef ADDER_ARB_CARRY_EN
   localparam int AddW = Width + 1;
`else
   localparam int AddW = Width;
`endif

   logic [0:0]         r_state;
   logic [IdWidth-1:0] r_last_grant;
   logic [IdWidth-1:0] r_rsp_id;
   logic [Width-1:0]   r_rsp_sum;
   logic               r_rsp_carry;

   logic               w_found;
   logic [IdWidth-1:0] w_grant;
   logic               w_accept;
   logic               w_req_fire;
   logic [Width-1:0]   w_op_a;
   logic [Width-1:0]   w_op_b;
   logic [AddW-1:0]    w_add_a;
   logic [AddW-1:0]    w_add_b;
   logic [AddW-1:0]    w_add_sum;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      w_found = 1'b0;
      w_grant = r_last_grant;
      for (int k = 1; k <= NumReq; k++) begin
         if (!w_found && iReqValid[IdWidth'((int'(r_last_grant) + k) % NumReq)]) begin
            w_found = 1'b1;
            w_grant = IdWidth'((int'(r_last_grant) + k) % NumReq);
         end
      end
   end

   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (IdWidth'(i) == w_grant) begin
            w_op_a = iReqData0[i*Width +: Width];
            w_op_b = iReqData1[i*Width +: Width];
         end
      end
   end

   assign w_accept   = (r_state == ST_EMPTY) || iRspReady;
   assign w_req_fire = !iRst && w_accept && w_found;

   always_comb begin
      oReqReady = '0;
      if (w_req_fire) oReqReady[w_grant] = 1'b1;
   end

`ifdef ADDER_ARB_CARRY_EN
   assign w_add_a = {1'b0, w_op_a};
   assign w_add_b = {1'b0, w_op_b};
`else
   assign w_add_a = w_op_a;
   assign w_add_b = w_op_b;
`endif

   Adder #(.Width(AddW)) u_adder (
      .iA   (w_add_a),
      .iB   (w_add_b),
      .oSum (w_add_sum)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state      <= ST_EMPTY;
         r_last_grant <= IdWidth'(NumReq - 1);
         r_rsp_id     <= '0;
         r_rsp_sum    <= '0;
         r_rsp_carry  <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_req_fire) r_state <= ST_FULL;
            ST_FULL:  if (!w_req_fire && iRspReady) r_state <= ST_EMPTY;
            default:  r_state <= ST_EMPTY;
         endcase
         if (w_req_fire) begin
            r_last_grant <= w_grant;
            r_rsp_id     <= w_grant;
            r_rsp_sum    <= w_add_sum[Width-1:0];
`ifdef ADDER_ARB_CARRY_EN
            r_rsp_carry  <= w_add_sum[Width];
`else
            r_rsp_carry  <= 1'b0;
`endif
         end
      end
   end

   // oRspValid is the slot FSM state itself.
   assign oRspValid = (r_state == ST_FULL);
   assign oRspId    = r_rsp_id;
   assign oRspSum   = r_rsp_sum;
`ifdef ADDER_ARB_CARRY_EN
   assign oRspCarry = r_rsp_carry;
`else
   logic w_unused_carry;
   assign w_unused_carry = r_rsp_carry;
`endif

endmodule

// Shared combinational adder; the sum wraps at its own width.
module Adder #(
   parameter int Width = 8
) (
   input  logic [Width-1:0] iA,
   input  logic [Width-1:0] iB,
   output logic [Width-1:0] oSum
);
   assign oSum = iA + iB;
endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: reference round-robin model plus expected-result queue.
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int QW = 1 + IW + W;

  logic           iClk = 1'b0;
  logic           iRst;
  logic [N-1:0]   iReqValid;
  logic [N-1:0]   oReqReady;
  logic [N*W-1:0] iReqData0;
  logic [N*W-1:0] iReqData1;
  logic           oRspValid;
  logic           iRspReady;
  logic [IW-1:0]  oRspId;
  logic [W-1:0]   oRspSum;
`ifdef ADDER_ARB_CARRY_EN
  logic           oRspCarry;
`endif

  adder_arbiter #(.Width(W), .NumReq(N)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReqValid (iReqValid),
    .oReqReady (oReqReady),
    .iReqData0 (iReqData0),
    .iReqData1 (iReqData1),
    .oRspValid (oRspValid),
    .iRspReady (iRspReady),
    .oRspId    (oRspId),
    .oRspSum   (oRspSum)
`ifdef ADDER_ARB_CARRY_EN
    ,.oRspCarry (oRspCarry)
`endif
  );

  // clock / reset
  always #5 iClk = ~iClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: entries are {carry, id, sum}
  logic [QW-1:0] exp_q[$];
  logic          m_full   = 1'b0;
  logic          m_zeroed = 1'b1;
  int            m_last   = N - 1;
  int            m_grant;
  int            idx;
  logic          m_found;
  logic          m_accept;
  logic [N-1:0]  m_ready;
  logic [W:0]    m_wide;
  logic [QW-1:0] head;

  always @(negedge iClk) begin
    check("rsp_valid", 32'(oRspValid), 32'(m_full));
    if (iRst) begin
      check("rst_ready", 32'(oReqReady), 32'h0);
      if (m_zeroed) begin
        check("rst_sum", 32'(oRspSum), 32'h0);
        check("rst_id", 32'(oRspId), 32'h0);
      end
      m_full   = 1'b0;
      m_zeroed = 1'b1;
      m_last   = N - 1;
      exp_q.delete();
    end else begin
      if (m_full) begin
        if (exp_q.size() != 1) begin
          check("q_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          head = exp_q[0];
          check("rsp_id", 32'(oRspId), 32'(head[W +: IW]));
          check("rsp_sum", 32'(oRspSum), 32'(head[W-1:0]));
`ifdef ADDER_ARB_CARRY_EN
          check("rsp_carry", 32'(oRspCarry), 32'(head[QW-1]));
`endif
          if (iRspReady) void'(exp_q.pop_front());
        end
      end
      m_accept = !m_full || iRspReady;
      m_found  = 1'b0;
      m_grant  = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_last + 1 + k) % N;
        if (!m_found && iReqValid[idx]) begin
          m_found = 1'b1;
          m_grant = idx;
        end
      end
      m_ready = '0;
      if (m_found && m_accept) m_ready[m_grant] = 1'b1;
      check("req_ready", 32'(oReqReady), 32'(m_ready));
      if (m_found && m_accept) begin
        m_wide = {1'b0, iReqData0[m_grant*W +: W]} + {1'b0, iReqData1[m_grant*W +: W]};
        exp_q.push_back({m_wide[W], IW'(m_grant), m_wide[W-1:0]});
        m_last   = m_grant;
        m_full   = 1'b1;
        m_zeroed = 1'b0;
      end else if (m_full && iRspReady) begin
        m_full = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic drive(input logic [N-1:0] v, input logic rr);
    @(posedge iClk);
    #1;
    iReqValid = v;
    iRspReady = rr;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    iReqData0[i*W +: W] = a;
    iReqData1[i*W +: W] = b;
  endtask

  initial begin
    iRst      = 1'b1;
    iReqValid = '1;
    iRspReady = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, W'(i + 'h10), 8'h00);
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;

    // round robin, all valid, consumer ready
    repeat (9) drive('1, 1'b1);

    // backpressure for 3 cycles, then release
    repeat (3) drive('1, 1'b0);
    repeat (2) drive('1, 1'b1);
    repeat (2) drive('0, 1'b1);

    // single request from requester 2
    set_data(2, 8'h01, 8'h02);
    drive(4'b0100, 1'b1);
    repeat (2) drive('0, 1'b1);

    // wrap-around and carry cases
    set_data(1, 8'hFF, 8'h02);
    drive(4'b0010, 1'b1);
    set_data(3, 8'h7F, 8'h01);
    drive(4'b1000, 1'b1);
    set_data(0, 8'h80, 8'h80);
    drive(4'b0001, 1'b0);
    drive('0, 1'b1);
    repeat (2) drive('0, 1'b1);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) set_data(i, W'($urandom), W'($urandom));
      drive(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0));
    end
    repeat (2) drive('0, 1'b1);

    // reset while FULL and stalled
    drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b0);
    @(posedge iClk);
    #1;
    iRst      = 1'b1;
    iReqValid = '1;
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    iRspReady = 1'b1;
    repeat (5) drive('1, 1'b1);
    repeat (2) drive('0, 1'b1);

    @(negedge iClk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
